// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and default sizes for the shift-register sequencing controller.
// FSM state encoding, default parameters and a counter-width helper.
package shift_seq_ctrl_pkg;

    localparam int SSC_WIDTH = 16;
    localparam int SSC_DIV_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // shift_cnt must be able to hold WIDTH itself, not just WIDTH-1
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Control/status bundle between a sequencer user (master) and shift_seq_ctrl (slave).
interface shift_seq_ctrl_if
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = SSC_WIDTH,
    parameter int DIV_W = SSC_DIV_W
) ();

    logic                      start;
    logic                      step_btn;
    logic                      mode;
    logic [DIV_W-1:0]          rate;
    logic                      ld;
    logic                      step;
    logic                      busy;
    logic                      done;
    logic [cnt_w(WIDTH)-1:0]   shift_cnt;

    modport master (
        output start, step_btn, mode, rate,
        input  ld, step, busy, done, shift_cnt
    );

    modport slave (
        input  start, step_btn, mode, rate,
        output ld, step, busy, done, shift_cnt
    );

endinterface

// File: rtl/shift_seq_ctrl_tick_gen.sv
// Auto-step prescaler: counts 0..period-1 and flags the terminal count.
// A period of 0 behaves as 1, i.e. tick on every cycle.
module tick_gen #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] last;

    always_comb begin
        last  = (period == '0) ? '0 : period - 1'b1;
        // >= so that lowering the period mid-count cannot cause a long wrap
        tick  = (cnt_q >= last);
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Run sequencer for a WIDTH-bit shift register: load strobe, then WIDTH step
// strobes from either a manual button or an internal prescaler, then done.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = SSC_WIDTH,
    parameter int DIV_W = SSC_DIV_W
) (
    input  logic                clk,
    input  logic                rst,
    shift_seq_ctrl_if.slave     bus
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    state_e          state_q, state_d;
    logic            start_prev_q, btn_prev_q, mode_q;
    logic            ld_q, ld_d;
    logic            step_q, step_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            start_edge, btn_edge, mode_chg;
    logic            tick, tick_clr, fire;

    assign start_edge = bus.start & ~start_prev_q;
    assign btn_edge   = bus.step_btn & ~btn_prev_q;
    assign mode_chg   = bus.mode ^ mode_q;

    // Prescaler only runs in auto RUN; a mode flip restarts it from zero
    assign tick_clr = (state_q != RUN) || mode_chg || !mode_q;
    assign fire     = !mode_chg && (mode_q ? tick : btn_edge);

    tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr    (tick_clr),
        .period (bus.rate),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        case (state_q)
            IDLE: if (start_edge) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (start_edge) begin
                    state_d = LOAD;
                end else if (cnt_q == FULL) begin
                    state_d = DONE;
                end else if (fire) begin
                    step_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: state_d = start_edge ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == LOAD) cnt_d = '0;
        // Strobes are decoded from the next state so they line up with state_q
        ld_d   = (state_d == LOAD);
        busy_d = (state_d == LOAD) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b1;
            btn_prev_q   <= 1'b1;
            mode_q       <= 1'b0;
            ld_q         <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= bus.start;
            btn_prev_q   <= bus.step_btn;
            mode_q       <= bus.mode;
            ld_q         <= ld_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.ld        = ld_q;
    assign bus.step      = step_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.shift_cnt = cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized bench for shift_seq_ctrl: expected ld/step/done cycle numbers are
// derived from the run rules and compared against a negedge event monitor.
module tb_shift_seq_ctrl;
    import shift_seq_ctrl_pkg::*;

    localparam int W  = SSC_WIDTH;
    localparam int DW = SSC_DIV_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    shift_seq_ctrl_if #(.WIDTH(W), .DIV_W(DW)) bus ();

    shift_seq_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int obs_ld[$], obs_step[$], obs_done[$];
    int exp_ld[$], exp_step[$], exp_done[$];
    int run_steps = 0;
    logic prev_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Event monitor: records when strobes occur and checks per-cycle invariants
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("ld_step_exclusive", 32'(bus.ld & bus.step), 0);
            if (bus.ld) begin
                obs_ld.push_back(cyc);
                run_steps = 0;
                check_eq("cnt_at_ld", 32'(bus.shift_cnt), 0);
            end
            if (bus.step) begin
                obs_step.push_back(cyc);
                run_steps++;
                check_eq("cnt_after_step", 32'(bus.shift_cnt), run_steps);
            end
            if (bus.done) begin
                obs_done.push_back(cyc);
                check_eq("busy_at_done", 32'(bus.busy), 0);
                check_eq("busy_before_done", 32'(prev_busy), 1);
                check_eq("cnt_at_done", 32'(bus.shift_cnt), W);
            end
            prev_busy = bus.busy;
        end
    end

    task automatic clear_all();
        obs_ld.delete(); obs_step.delete(); obs_done.delete();
        exp_ld.delete(); exp_step.delete(); exp_done.delete();
    endtask

    // Auto run launched with ld at cycle l: step k lands at l+1+k*period
    task automatic add_auto(input int l, input int r, input int n);
        int p;
        p = (r == 0) ? 1 : r;
        for (int k = 1; k <= n; k++) exp_step.push_back(l + 1 + k * p);
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        s = cyc;
    endtask

    // Caller is at a negedge in RUN with step_btn low already sampled
    task automatic manual_steps(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.step_btn = 1'b1;
            exp_step.push_back(cyc + 1);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bus.step_btn = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget, input bit toggle_btn);
        int k;
        k = 0;
        while (obs_done.size() == 0 && k < budget) begin
            @(negedge clk);
            if (toggle_btn) bus.step_btn = 1'($urandom_range(0, 1));
            k++;
        end
        check_eq("done_seen", 32'(obs_done.size() > 0), 1);
        bus.step_btn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_steps(input int n, input int budget, input bit toggle_btn, output int t);
        int seen, k;
        seen = 0; k = 0; t = -1;
        while (seen < n && k < budget) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.step) seen++;
            if (seen == n) t = cyc;
            else if (toggle_btn) bus.step_btn = 1'($urandom_range(0, 1));
            k++;
        end
        check_eq("steps_reached", seen, n);
    endtask

    task automatic compare_run(input string tag);
        int m;
        check_eq({tag, "_ld_count"}, obs_ld.size(), exp_ld.size());
        m = (obs_ld.size() < exp_ld.size()) ? obs_ld.size() : exp_ld.size();
        for (int i = 0; i < m; i++) check_eq({tag, "_ld_cycle"}, obs_ld[i], exp_ld[i]);
        check_eq({tag, "_step_count"}, obs_step.size(), exp_step.size());
        m = (obs_step.size() < exp_step.size()) ? obs_step.size() : exp_step.size();
        for (int i = 0; i < m; i++) check_eq({tag, "_step_cycle"}, obs_step[i], exp_step[i]);
        check_eq({tag, "_done_count"}, obs_done.size(), exp_done.size());
        m = (obs_done.size() < exp_done.size()) ? obs_done.size() : exp_done.size();
        for (int i = 0; i < m; i++) check_eq({tag, "_done_cycle"}, obs_done[i], exp_done[i]);
        $display("run %s: ld=%0d step=%0d done=%0d", tag, obs_ld.size(), obs_step.size(), obs_done.size());
        clear_all();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ld"},   32'(bus.ld),        0);
        check_eq({tag, "_step"}, 32'(bus.step),      0);
        check_eq({tag, "_busy"}, 32'(bus.busy),      0);
        check_eq({tag, "_done"}, 32'(bus.done),      0);
        check_eq({tag, "_cnt"},  32'(bus.shift_cnt), 0);
    endtask

    task automatic auto_run(input string tag, input int r);
        int s;
        bus.mode = 1'b1;
        bus.rate = DW'(r);
        pulse_start(s);
        exp_ld.push_back(s + 1);
        add_auto(s + 1, r, W);
        exp_done.push_back(exp_step[$] + 1);
        wait_done(20 * W + 40, 1'b1);
        compare_run(tag);
    endtask

    initial begin
        int s, t, r;
        bus.start    = 1'b0;
        bus.step_btn = 1'b0;
        bus.mode     = 1'b0;
        bus.rate     = DW'(4);
        #1 rst = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_all();

        // Manual run
        bus.mode = 1'b0;
        pulse_start(s);
        exp_ld.push_back(s + 1);
        repeat (2) @(negedge clk);
        manual_steps(W);
        exp_done.push_back(exp_step[$] + 1);
        wait_done(20, 1'b0);
        compare_run("manual");

        // Auto runs: nominal, rate 0, rate 1, random
        auto_run("auto_r4", 4);
        auto_run("auto_r0", 0);
        auto_run("auto_r1", 1);
        auto_run("auto_rnd", $urandom_range(2, 5));

        // Abort after step 7, then a full run from the new load
        r = $urandom_range(1, 3);
        bus.mode = 1'b1;
        bus.rate = DW'(r);
        pulse_start(s);
        exp_ld.push_back(s + 1);
        add_auto(s + 1, r, 7);
        wait_steps(7, 10 * r + 20, 1'b0, t);
        bus.start = 1'b1;
        exp_ld.push_back(t + 1);
        add_auto(t + 1, r, W);
        exp_done.push_back(exp_step[$] + 1);
        wait_done(20 * W + 40, 1'b0);
        compare_run("abort");

        // Auto to manual switch after step 5
        r = $urandom_range(2, 4);
        bus.mode = 1'b1;
        bus.rate = DW'(r);
        pulse_start(s);
        exp_ld.push_back(s + 1);
        add_auto(s + 1, r, 5);
        wait_steps(5, 10 * r + 20, 1'b1, t);
        bus.mode     = 1'b0;
        bus.step_btn = 1'b0;
        repeat (2) @(negedge clk);
        manual_steps(W - 5);
        exp_done.push_back(exp_step[$] + 1);
        wait_done(20, 1'b0);
        compare_run("mode_switch");

        // Async reset mid-run with start held high
        bus.mode = 1'b1;
        bus.rate = DW'(2);
        pulse_start(s);
        wait_steps(3, 40, 1'b0, t);
        bus.start = 1'b1;
        #2 rst = 1'b1;
        #1 check_outputs_zero("mid_run_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_all();
        repeat (12) @(negedge clk);
        check_eq("no_ld_after_reset", obs_ld.size(), 0);
        check_eq("no_step_after_reset", obs_step.size(), 0);
        pulse_start(s);
        exp_ld.push_back(s + 1);
        add_auto(s + 1, 2, W);
        exp_done.push_back(exp_step[$] + 1);
        wait_done(20 * W + 40, 1'b0);
        compare_run("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
